lock_reg_sequencer: RTL and testbench

//  Command-driven sequencer upstream of the lockable 16-bit config register.

---
 rtl/lock_reg_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_lock_reg_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lock_reg_sequencer
// Brief    : Command sequencer in front of a lockable config register.
//            Accepts WRITE/LOCK/READ commands and drives the register strobes.
//            Each write is checked by reading the register back.
//            Every command produces one response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module lock_reg_sequencer #(
    parameter int DATA_W     = 16,
    parameter int VERIFY_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              scan_mode,
    input  logic              debug_unlocked,
    output logic [DATA_W-1:0] reg_data_in,
    output logic              reg_write,
    output logic              reg_lock,
    input  logic [DATA_W-1:0] reg_data_out,
    output logic              rsp_valid,
    output logic [2:0]        rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic              locked
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_WRITE  = 3'd1;
    localparam logic [2:0] c_S_VERIFY = 3'd2;
    localparam logic [2:0] c_S_LOCK   = 3'd3;
    localparam logic [2:0] c_S_RESP   = 3'd4;
    localparam logic [2:0] c_S_LOCKED = 3'd5;

    localparam logic [1:0] c_OP_WRITE = 2'd0;
    localparam logic [1:0] c_OP_LOCK  = 2'd1;
    localparam logic [1:0] c_OP_READ  = 2'd2;

    localparam logic [2:0] c_RSP_OK      = 3'd0;
    localparam logic [2:0] c_RSP_VFAIL   = 3'd1;
    localparam logic [2:0] c_RSP_LOCKED  = 3'd2;
    localparam logic [2:0] c_RSP_DBG     = 3'd3;
    localparam logic [2:0] c_RSP_BAD_OP  = 3'd4;

    localparam logic [3:0] c_CNT_INIT = 4'(VERIFY_LAT - 1);

    logic [2:0]        r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_write;
    logic              r_lock;
    logic              r_locked;
    logic              r_rsp_valid;
    logic [2:0]        r_rsp_code;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_ready;

    logic [2:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_write_nxt;
    logic              w_lock_nxt;
    logic              w_locked_nxt;
    logic              w_rsp_valid_nxt;
    logic [2:0]        w_rsp_code_nxt;
    logic [DATA_W-1:0] w_rsp_data_nxt;

    // State register and registered copies of every output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_data      <= '0;
            r_write     <= 1'b0;
            r_lock      <= 1'b0;
            r_locked    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= '0;
            r_rsp_data  <= '0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data      <= w_data_nxt;
            r_write     <= w_write_nxt;
            r_lock      <= w_lock_nxt;
            r_locked    <= w_locked_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_code  <= w_rsp_code_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_ready     <= (w_state_nxt == c_S_IDLE) || (w_state_nxt == c_S_LOCKED);
        end
    end

    // Next-state and next-output decode; commands are decoded in the accept cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_data_nxt      = r_data;
        w_write_nxt     = 1'b0;
        w_lock_nxt      = 1'b0;
        w_locked_nxt    = r_locked;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_code_nxt  = c_RSP_OK;
        w_rsp_data_nxt  = '0;
        case (r_state)
            c_S_IDLE, c_S_LOCKED: begin
                if (cmd_valid) begin
                    // Default: single-cycle response
                    w_state_nxt     = c_S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    case (cmd_op)
                        c_OP_WRITE: begin
                            if (r_state == c_S_LOCKED) begin
                                // Lock outranks scan/debug rejection
                                w_rsp_code_nxt = c_RSP_LOCKED;
                            end else if (scan_mode || debug_unlocked) begin
                                w_rsp_code_nxt = c_RSP_DBG;
                            end else begin
                                w_rsp_valid_nxt = 1'b0;
                                w_data_nxt      = cmd_data;
                                w_write_nxt     = 1'b1;
                                w_state_nxt     = c_S_WRITE;
                            end
                        end
                        c_OP_LOCK: begin
                            if (r_state == c_S_IDLE) begin
                                // Lock is honoured regardless of scan/debug
                                w_rsp_valid_nxt = 1'b0;
                                w_lock_nxt      = 1'b1;
                                w_locked_nxt    = 1'b1;
                                w_state_nxt     = c_S_LOCK;
                            end
                        end
                        c_OP_READ: begin
                            w_rsp_data_nxt = reg_data_out;
                        end
                        default: begin
                            w_rsp_code_nxt = c_RSP_BAD_OP;
                        end
                    endcase
                end
            end
            c_S_WRITE: begin
                w_state_nxt = c_S_VERIFY;
                w_cnt_nxt   = c_CNT_INIT;
            end
            c_S_VERIFY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt     = c_S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_code_nxt  = (reg_data_out == r_data) ? c_RSP_OK : c_RSP_VFAIL;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_S_LOCK: begin
                w_state_nxt     = c_S_RESP;
                w_rsp_valid_nxt = 1'b1;
            end
            c_S_RESP: begin
                w_state_nxt = r_locked ? c_S_LOCKED : c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    assign cmd_ready   = r_ready;
    assign reg_data_in = r_data;
    assign reg_write   = r_write;
    assign reg_lock    = r_lock;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_code    = r_rsp_code;
    assign rsp_data    = r_rsp_data;
    assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_lock_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_reg_sequencer
// Brief    : Self-checking bench for lock_reg_sequencer with a lockable
//            register model, directed vector table and random commands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_reg_sequencer;

    localparam int DATA_W     = 16;
    localparam int VERIFY_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              scan_mode;
    logic              debug_unlocked;
    logic [DATA_W-1:0] reg_data_in;
    logic              reg_write;
    logic              reg_lock;
    logic [DATA_W-1:0] reg_data_out;
    logic              rsp_valid;
    logic [2:0]        rsp_code;
    logic [DATA_W-1:0] rsp_data;
    logic              locked;

    int total = 0;
    int bad   = 0;

    // Environment: lockable register with an optional forced-zero readback
    logic [DATA_W-1:0] r_reg_q;
    logic              r_reg_lk;
    logic              force0;

    lock_reg_sequencer #(.DATA_W(DATA_W), .VERIFY_LAT(VERIFY_LAT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .scan_mode(scan_mode),
        .debug_unlocked(debug_unlocked), .reg_data_in(reg_data_in),
        .reg_write(reg_write), .reg_lock(reg_lock), .reg_data_out(reg_data_out),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_data(rsp_data),
        .locked(locked)
    );

    always #5 clk = ~clk;

    // Register model downstream of the sequencer
    always @(posedge clk) begin
        if (reset) begin
            r_reg_q  <= '0;
            r_reg_lk <= 1'b0;
        end else begin
            if (reg_lock) r_reg_lk <= 1'b1;
            if (reg_write && !r_reg_lk) r_reg_q <= reg_data_in;
        end
    end
    assign reg_data_out = force0 ? '0 : r_reg_q;

    // Strobe invariants checked every cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_write && reg_lock) begin
                bad++;
                $display("FAIL strobe_overlap: write=%0b lock=%0b required not both", reg_write, reg_lock);
            end
            if (reg_write && locked) begin
                bad++;
                $display("FAIL write_while_locked: write=%0b locked=%0b", reg_write, locked);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one command, wait for its response, and collect what happened
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] data,
                           input logic scan, input logic dbg, input logic f0,
                           output logic [2:0] code, output logic [15:0] rd,
                           output int lat, output int nwr, output int nlk);
        bit rdy, got;
        code = 'x; rd = 'x; lat = -1; nwr = 0; nlk = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        scan_mode = scan; debug_unlocked = dbg; force0 = f0;
        rdy = 0;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) begin rdy = 1; break; end
            @(negedge clk);
        end
        if (!rdy) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            got = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (k == 1) cmd_valid = 1'b0;
                nwr += int'(reg_write);
                nlk += int'(reg_lock);
                if (rsp_valid) begin
                    got = 1; lat = k; code = rsp_code; rd = rsp_data;
                    break;
                end
            end
            if (!got) chk("rsp_timeout", 32'd0, 32'd1);
            @(negedge clk);
            chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
            chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
            nwr += int'(reg_write);
            nlk += int'(reg_lock);
        end
        cmd_valid = 1'b0; scan_mode = 1'b0; debug_unlocked = 1'b0; force0 = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic        scan;
        logic        dbg;
        logic        f0;
        logic [2:0]  code;
        logic [15:0] rdata;
        int          lat;
        int          nwr;
        int          nlk;
        logic        lk;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [2:0]  code;
        logic [15:0] rd;
        int lat, nwr, nlk;
        bit          m_locked;
        logic [15:0] m_reg;
        logic [1:0]  op;
        logic [15:0] data;
        logic        scan, dbg, f0;
        logic [2:0]  e_code;
        logic [15:0] e_rd;
        int          e_lat, e_nwr, e_nlk;
        int          r;

        //            op    data      scn   dbg   f0    code  rdata     lat nwr nlk lk
        tbl[0]  = '{2'd0, 16'hA5A5, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3, 1, 0, 1'b0};
        tbl[1]  = '{2'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'hA5A5, 1, 0, 0, 1'b0};
        tbl[2]  = '{2'd0, 16'h1111, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0000, 1, 0, 0, 1'b0};
        tbl[3]  = '{2'd0, 16'h2222, 1'b0, 1'b1, 1'b0, 3'd3, 16'h0000, 1, 0, 0, 1'b0};
        tbl[4]  = '{2'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'hA5A5, 1, 0, 0, 1'b0};
        tbl[5]  = '{2'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0000, 3, 1, 0, 1'b0};
        tbl[6]  = '{2'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0000, 1, 0, 0, 1'b0};
        tbl[7]  = '{2'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'hFFFF, 1, 0, 0, 1'b0};
        tbl[8]  = '{2'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 2, 0, 1, 1'b1};
        tbl[9]  = '{2'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0000, 1, 0, 0, 1'b1};
        tbl[10] = '{2'd0, 16'h5678, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0000, 1, 0, 0, 1'b1};
        tbl[11] = '{2'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'hFFFF, 1, 0, 0, 1'b1};
        tbl[12] = '{2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1, 0, 0, 1'b1};
        tbl[13] = '{2'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0000, 1, 0, 0, 1'b1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        scan_mode = 1'b0; debug_unlocked = 1'b0; force0 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", {30'd0, reg_write, reg_lock}, 32'd0);
        chk("rst_data_in", 32'(reg_data_in), 32'd0);

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            run_cmd(tbl[i].op, tbl[i].data, tbl[i].scan, tbl[i].dbg, tbl[i].f0,
                    code, rd, lat, nwr, nlk);
            chk($sformatf("v%0d_code", i), 32'(code), 32'(tbl[i].code));
            chk($sformatf("v%0d_data", i), 32'(rd), 32'(tbl[i].rdata));
            chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_nwr", i), nwr, tbl[i].nwr);
            chk($sformatf("v%0d_nlk", i), nlk, tbl[i].nlk);
            chk($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
        end

        // Reset clears the sticky lock
        do_reset();
        @(negedge clk);
        chk("lock_cleared_by_reset", 32'(locked), 32'd0);

        // Reset in the middle of a write verify abandons the command
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'h3C3C;
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_write_strobe", 32'(reg_write), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_no_rsp_in_reset", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready_after_reset", 32'(cmd_ready), 32'd1);
        chk("mid_locked", 32'(locked), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end

        // Random commands against a command-level reference model
        m_locked = 0;
        m_reg    = 16'h3C3C;
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 0) begin
                do_reset();
                m_locked = 0;
                m_reg    = '0;
            end
            r    = $urandom_range(0, 99);
            op   = (r < 3) ? 2'd1 : (r < 50) ? 2'd0 : (r < 80) ? 2'd2 : 2'd3;
            data = 16'($urandom);
            scan = ($urandom_range(0, 3) == 0);
            dbg  = ($urandom_range(0, 3) == 0);
            f0   = (op == 2'd0) && ($urandom_range(0, 7) == 0);

            e_rd = '0; e_nwr = 0; e_nlk = 0; e_lat = 1; e_code = 3'd0;
            case (op)
                2'd0: begin
                    if (m_locked)          e_code = 3'd2;
                    else if (scan || dbg)  e_code = 3'd3;
                    else begin
                        e_code = f0 ? 3'd1 : 3'd0;
                        e_lat  = 2 + VERIFY_LAT;
                        e_nwr  = 1;
                        m_reg  = data;
                    end
                end
                2'd1: begin
                    if (!m_locked) begin
                        e_lat = 2;
                        e_nlk = 1;
                    end
                    m_locked = 1;
                end
                2'd2: e_rd = m_reg;
                default: e_code = 3'd4;
            endcase

            run_cmd(op, data, scan, dbg, f0, code, rd, lat, nwr, nlk);
            chk($sformatf("r%0d_code", i), 32'(code), 32'(e_code));
            chk($sformatf("r%0d_data", i), 32'(rd), 32'(e_rd));
            chk($sformatf("r%0d_lat", i), lat, e_lat);
            chk($sformatf("r%0d_nwr", i), nwr, e_nwr);
            chk($sformatf("r%0d_nlk", i), nlk, e_nlk);
            chk($sformatf("r%0d_locked", i), 32'(locked), 32'(m_locked));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
